bcd_dabble: RTL

- Parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Fixed latency of WIDTH cycles per conversion, independent of operand value.
- Successor to the count-down BCD converter feeding the VGA score/digit renderers: the old block's latency scaled with operand value.
- Adds generic width/digit count, stable outputs during conversion, a done pulse, overflow saturation and optional leading-zero blanking.

---
 rtl/bcd_dabble_if.sv | 22 ++
 rtl/bcd_dabble.sv | 114 +++++++++++
 2 files changed

// File: rtl/bcd_dabble_if.sv
// Handshake/result bundle for the bcd_dabble binary-to-BCD converter.
// The blank field exists only when BCD_BLANK_EN is defined.
interface bcd_dabble_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  load;
  logic [WIDTH-1:0]      number;
  logic [4*DIGITS-1:0]   digits;
  logic                  ready;
  logic                  done;
  logic                  overflow;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output load, number, input digits, ready, done, overflow, blank);
  modport slave  (input load, number, output digits, ready, done, overflow, blank);
`else
  modport master (output load, number, input digits, ready, done, overflow);
  modport slave  (input load, number, output digits, ready, done, overflow);
`endif
endinterface

// File: rtl/bcd_dabble.sv
// Fixed-latency (WIDTH cycles) double-dabble binary-to-BCD converter with saturation.
// Define BCD_BLANK_EN to add the registered leading-zero blank output.
module bcd_dabble #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input logic         clk,
  input logic         reset_n,
  bcd_dabble_if.slave bus
);
  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] shift_q;
  logic [SW-1:0]   scratch_q;
  logic [CW-1:0]   cnt_q;
  logic            sticky_q;
  logic [SW-1:0]   digits_q;
  logic            overflow_q;
  logic            done_q;

  logic [SW-1:0]    adj;
  logic [SW-1:0]    scratch_nx;
  logic [WIDTH-1:0] shift_nx;
  logic             sticky_nx;
  logic             final_ovf;

  always_comb begin
    adj = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                    : scratch_q[4*k +: 4];
    end
    scratch_nx = {adj[SW-2:0], shift_q[WIDTH-1]};
    shift_nx   = {shift_q[WIDTH-2:0], 1'b0};
    // A 1 leaving the scratch MSB means the value no longer fits in DIGITS digits.
    sticky_nx  = sticky_q | adj[SW-1];
    final_ovf  = sticky_nx | (scratch_nx[SW-1 -: 4] > 4'd9);
  end

`ifdef BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nx;
  logic              lead_zero;

  always_comb begin
    blank_nx  = '0;
    lead_zero = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      lead_zero   = lead_zero & (scratch_nx[4*k +: 4] == 4'd0);
      blank_nx[k] = lead_zero;
    end
    blank_nx[0] = 1'b0;
    if (final_ovf) blank_nx = '0;
  end

  assign bus.blank = blank_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q    <= BlankRst;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load) begin
            shift_q   <= bus.number;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= CW'(WIDTH);
            state_q   <= StShift;
          end
        end
        StShift: begin
          shift_q   <= shift_nx;
          scratch_q <= scratch_nx;
          sticky_q  <= sticky_nx;
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            digits_q   <= final_ovf ? {DIGITS{4'h9}} : scratch_nx;
            overflow_q <= final_ovf;
            done_q     <= 1'b1;
            state_q    <= StIdle;
`ifdef BCD_BLANK_EN
            blank_q    <= blank_nx;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.digits   = digits_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;
  assign bus.ready    = (state_q == StIdle);
endmodule
